// File: rtl/restoring_divider.sv
// restoring_divider: N-bit sequential restoring divider, start/fin handshake.
// Define SIGNED_DIV_EN for two's-complement operands (truncating division).
module restoring_divider #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy,
    output logic         fin,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        SUB,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [N:0]    a_q, a_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  m_q, m_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  quo_q, quo_d;
    logic [N-1:0]  rem_q, rem_d;
    logic          dbz_q, dbz_d;

    logic [N:0]    trial;
    logic [N-1:0]  dvd_mag;
    logic [N-1:0]  dsr_mag;
    logic [N:0]    a_nx;
    logic [N-1:0]  q_nx;

`ifdef SIGNED_DIV_EN
    logic          negq_q, negq_d;
    logic          negr_q, negr_d;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
`ifdef SIGNED_DIV_EN
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
`ifdef SIGNED_DIV_EN
            negq_q  <= negq_d;
            negr_q  <= negr_d;
`endif
        end
    end

    // Operand magnitudes fed to the unsigned iteration
    always_comb begin
`ifdef SIGNED_DIV_EN
        dvd_mag = dividend[N-1] ? -dividend : dividend;
        dsr_mag = divisor[N-1]  ? -divisor  : divisor;
`else
        dvd_mag = dividend;
        dsr_mag = divisor;
`endif
    end

    assign trial = a_q - {1'b0, m_q};

    always_comb begin
        a_nx = a_q;
        q_nx = {q_q[N-1:1], 1'b0};
        if (!trial[N]) begin
            a_nx = trial;
            q_nx = {q_q[N-1:1], 1'b1};
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
`ifdef SIGNED_DIV_EN
        negq_d  = negq_q;
        negr_d  = negr_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    if (divisor == '0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = SHIFT;
                        a_d     = '0;
                        q_d     = dvd_mag;
                        m_d     = dsr_mag;
                        cnt_d   = CW'(N);
`ifdef SIGNED_DIV_EN
                        negq_d  = dividend[N-1] ^ divisor[N-1];
                        negr_d  = dividend[N-1];
`endif
                    end
                end
            end
            SHIFT: begin
                a_d     = {a_q[N-1:0], q_q[N-1]};
                q_d     = {q_q[N-2:0], 1'b0};
                state_d = SUB;
            end
            SUB: begin
                a_d     = a_nx;
                q_d     = q_nx;
                cnt_d   = cnt_q - CW'(1);
                state_d = SHIFT;
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    dbz_d   = 1'b0;
`ifdef SIGNED_DIV_EN
                    quo_d   = negq_q ? -q_nx : q_nx;
                    rem_d   = negr_q ? -a_nx[N-1:0] : a_nx[N-1:0];
`else
                    quo_d   = q_nx;
                    rem_d   = a_nx[N-1:0];
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign busy        = (state_q == SHIFT) || (state_q == SUB);
    assign fin         = (state_q == DONE);

endmodule
